sharp_frame_writer: RTL and testbench

- Output end of the sharpening pipeline: accepts the sharpened pixel stream in raster order and writes it into the output frame RAM.
- Generates x/y counters and linear RAM addresses, and applies backpressure from the RAM port.
- Raises halt once a full IMG_W x IMG_H frame has been written, so the top-level bench can stop simulation.

---
 rtl/sharp_pkg.sv | 25 ++
 rtl/sharp_frame_writer_if.sv | 25 ++
 rtl/sharp_frame_writer_raster_counter.sv | 67 ++++++
 rtl/sharp_frame_writer.sv | 130 +++++++++++++
 tb/tb_sharp_frame_writer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sharp_pkg.sv
// Shared definitions for the sharpening pipeline: FSM states, default image
// geometry and pixel/address types.
package sharp_pkg;

    localparam int unsigned IMG_W_DEF     = 800;
    localparam int unsigned IMG_H_DEF     = 600;
    localparam int unsigned PIX_W_DEF     = 8;
    localparam int unsigned ADDR_W_DEF    = 19;
    localparam int unsigned FRAME_PIX_DEF = IMG_W_DEF * IMG_H_DEF;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [PIX_W_DEF-1:0]  pix_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    function automatic int unsigned frame_pix(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/sharp_frame_writer_if.sv
// Pixel-stream handshake plus frame-RAM write port of the frame writer.
interface sharp_frame_writer_if #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ADDR_W = 19
);

    logic [PIX_W-1:0]  pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic              mem_stall;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_data;

    modport slave (
        input  pix_in, pix_valid, mem_stall,
        output pix_ready, mem_we, mem_addr, mem_data
    );

    modport master (
        output pix_in, pix_valid, mem_stall,
        input  pix_ready, mem_we, mem_addr, mem_data
    );

endinterface

// File: rtl/sharp_frame_writer_raster_counter.sv
// Raster-order x/y counter with an incrementally generated linear address,
// an image-edge flag and a last-pixel (wrap) flag.
module raster_counter #(
    parameter int unsigned W      = 800,
    parameter int unsigned H      = 600,
    parameter int unsigned ADDR_W = 19,
    localparam int unsigned XW    = (W > 1) ? $clog2(W) : 1,
    localparam int unsigned YW    = (H > 1) ? $clog2(H) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic [ADDR_W-1:0] addr,
    output logic              at_edge,
    output logic              wrap
);

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              x_last, y_last;

    assign x_last  = (x_q == XW'(W - 1));
    assign y_last  = (y_q == YW'(H - 1));
    assign wrap    = x_last && y_last;
    assign at_edge = (x_q == '0) || x_last || (y_q == '0) || y_last;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clr) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (adv) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            // Linear address follows the raster walk directly; no y*W product needed.
            addr_d = wrap ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign addr = addr_q;

endmodule

// File: rtl/sharp_frame_writer.sv
// Writes the sharpened raster stream into the output frame RAM, then raises halt.
// Optional BORDER_FILL_EN: the writer generates the one-pixel border itself.
module sharp_frame_writer
    import sharp_pkg::*;
#(
    parameter int unsigned      IMG_W      = IMG_W_DEF,
    parameter int unsigned      IMG_H      = IMG_H_DEF,
    parameter int unsigned      PIX_W      = PIX_W_DEF,
    parameter int unsigned      ADDR_W     = ADDR_W_DEF,
    parameter logic [PIX_W-1:0] BORDER_PIX = '0,
    localparam int unsigned     XW         = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int unsigned     YW         = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    sharp_frame_writer_if.slave bus,
    output logic              busy,
    output logic              halt,
    output logic [ADDR_W-1:0] pix_count
);

    state_t            state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [PIX_W-1:0]  mem_data_q, mem_data_d;
    logic [ADDR_W-1:0] pix_count_q, pix_count_d;

    logic              cnt_clr, cnt_adv, cnt_edge, cnt_wrap;
    logic [XW-1:0]     cnt_x;
    logic [YW-1:0]     cnt_y;
    logic [ADDR_W-1:0] cnt_addr;
    logic              stall_hold, write_done, border_pos, pix_ready;

    raster_counter #(
        .W      (IMG_W),
        .H      (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (cnt_clr),
        .adv     (cnt_adv),
        .x       (cnt_x),
        .y       (cnt_y),
        .addr    (cnt_addr),
        .at_edge (cnt_edge),
        .wrap    (cnt_wrap)
    );

`ifdef BORDER_FILL_EN
    logic unused_cnt;
    assign border_pos = cnt_edge;
    assign unused_cnt = ^{cnt_x, cnt_y};
`else
    logic unused_cnt;
    assign border_pos = 1'b0;
    assign unused_cnt = ^{cnt_x, cnt_y, cnt_edge};
`endif

    assign stall_hold = mem_we_q && bus.mem_stall;
    assign write_done = mem_we_q && !bus.mem_stall;

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        pix_count_d = pix_count_q + ADDR_W'(write_done);
        cnt_clr     = 1'b0;
        cnt_adv     = 1'b0;
        pix_ready   = 1'b0;
        // A completed write retires unless a new one is loaded below.
        if (!stall_hold) begin
            mem_we_d = 1'b0;
        end
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    cnt_clr     = 1'b1;
                    pix_count_d = '0;
                end
            end
            RUN: begin
                pix_ready = !stall_hold && !border_pos;
                cnt_adv   = !stall_hold && (border_pos || bus.pix_valid);
                if (cnt_adv) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = cnt_addr;
                    mem_data_d = border_pos ? BORDER_PIX : bus.pix_in;
                    if (cnt_wrap) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (write_done) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            pix_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            pix_count_q <= pix_count_d;
        end
    end

    assign bus.pix_ready = pix_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign halt          = (state_q == DONE);
    assign pix_count     = pix_count_q;

endmodule

// File: tb/tb_sharp_frame_writer.sv
// Self-checking bench for sharp_frame_writer: raster-order scoreboard of RAM
// writes against the accepted pixel stream, with stalls, bubbles and resets.
module tb_sharp_frame_writer;
    import sharp_pkg::*;

    localparam int W = 4;
`ifdef BORDER_FILL_EN
    localparam int H   = 4;
    localparam int NIN = (W - 2) * (H - 2);
`else
    localparam int H   = 3;
    localparam int NIN = W * H;
`endif
    localparam int          FRAME = frame_pix(W, H);
    localparam int          AW    = 5;
    localparam logic [7:0]  BPIX  = 8'h00;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, halt;
    logic [AW-1:0] pix_count;

    sharp_frame_writer_if #(.PIX_W(8), .ADDR_W(AW)) bus ();

    sharp_frame_writer #(
        .IMG_W      (W),
        .IMG_H      (H),
        .PIX_W      (8),
        .ADDR_W     (AW),
        .BORDER_PIX (BPIX)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .halt      (halt),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_idx = 0;
    int last_wr_cyc = -10;
    int exp_q[$];
    bit prev_acc, prev_hold, prev_halt;
    logic [7:0]    prev_pix, hold_data;
    logic [AW-1:0] hold_addr;

    function automatic bit border_at(input int a);
        int x;
        int y;
        x = a % W;
        y = a / W;
`ifdef BORDER_FILL_EN
        return (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
`else
        return (x < 0) || (y < 0);
`endif
    endfunction

    // Reference model: writes must walk addresses 0..FRAME-1 in order, border
    // slots carry BPIX, every other slot the next accepted stream pixel.
    always @(negedge clk) begin
        int         a;
        logic [7:0] ed;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            wr_idx    = 0;
            prev_acc  = 0;
            prev_hold = 0;
            prev_halt = 0;
        end else begin
            if (start && !busy) begin
                exp_q.delete();
                wr_idx   = 0;
                prev_acc = 0;
            end
            if (prev_acc) begin
                checks++;
                if (bus.mem_we !== 1'b1 || bus.mem_data !== prev_pix) begin
                    errors++;
                    $display("FAIL latency: mem_we=%b mem_data=%h, required 1/%h", bus.mem_we, bus.mem_data, prev_pix);
                end
            end
            if (prev_hold) begin
                checks++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== hold_addr || bus.mem_data !== hold_data) begin
                    errors++;
                    $display("FAIL stall_hold: we=%b addr=%0d data=%h, required 1/%0d/%h",
                             bus.mem_we, bus.mem_addr, bus.mem_data, hold_addr, hold_data);
                end
            end
            if (bus.mem_we === 1'b1 && bus.mem_stall === 1'b1) begin
                checks++;
                if (bus.pix_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: pix_ready=%b, required 0", bus.pix_ready);
                end
            end
            if (bus.mem_we === 1'b1 && bus.mem_stall === 1'b0) begin
                a = wr_idx;
                ed = 8'h00;
                checks++;
                if (!border_at(a) && exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unsourced: addr=%0d with no pending pixel, required none", bus.mem_addr);
                end else begin
                    if (border_at(a)) ed = BPIX;
                    else ed = 8'(exp_q.pop_front());
                    if (bus.mem_addr !== AW'(a) || bus.mem_data !== ed) begin
                        errors++;
                        $display("FAIL write: addr=%0d data=%h, required %0d/%h", bus.mem_addr, bus.mem_data, a, ed);
                    end
                end
                wr_idx++;
                last_wr_cyc = cyc;
            end
            prev_acc = (bus.pix_valid === 1'b1) && (bus.pix_ready === 1'b1);
            if (prev_acc) begin
                prev_pix = bus.pix_in;
                exp_q.push_back(int'(bus.pix_in));
            end
            prev_hold = (bus.mem_we === 1'b1) && (bus.mem_stall === 1'b1);
            hold_addr = bus.mem_addr;
            hold_data = bus.mem_data;
            if (halt === 1'b1 && !prev_halt) begin
                checks++;
                if (cyc != last_wr_cyc + 1) begin
                    errors++;
                    $display("FAIL halt_timing: halt at cycle %0d, required %0d", cyc, last_wr_cyc + 1);
                end
            end
            prev_halt = (halt === 1'b1);
        end
    end

    // vmode: 0 valid held, 1 alternating, 2 random. smode: 0 none, 1 three-cycle
    // stall at address 5, 2 random. pmode: 0 random, 1 ramp, 2 fixed table.
    task automatic run_frame(input int vmode, input int smode, input bit mid_start,
                             input int reset_at, input int pmode);
        int         sent;
        int         stall_cnt;
        bit         stall_done;
        bit         v;
        logic [7:0] hold_d;
        logic [7:0] tab [4];
        int         pix_tab[$];
        tab = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        sent = 0;
        stall_cnt = 0;
        stall_done = 0;
        hold_d = 8'h00;
        for (int i = 0; i < NIN; i++) begin
            if (pmode == 1) pix_tab.push_back(i);
            else if (pmode == 2) pix_tab.push_back(int'(tab[i % 4]));
            else pix_tab.push_back(int'($urandom_range(0, 255)));
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1 || halt !== 1'b0) begin
            errors++;
            $display("FAIL start_run: busy=%b halt=%b, required 1/0", busy, halt);
        end
        for (int it = 0; it < 400; it++) begin
            if (smode == 1) begin
                if (!stall_done && bus.mem_we === 1'b1 && bus.mem_addr === AW'(5)) begin
                    stall_cnt = 3;
                    stall_done = 1;
                    hold_d = bus.mem_data;
                end
                bus.mem_stall = (stall_cnt > 0);
            end else if (smode == 2) begin
                bus.mem_stall = ($urandom_range(0, 3) == 0);
            end else begin
                bus.mem_stall = 1'b0;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (it % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.pix_valid = v && (sent < NIN);
            bus.pix_in    = (sent < NIN) ? 8'(pix_tab[sent]) : 8'($urandom_range(0, 255));
            start         = mid_start && (it == 4);
            #1;
            if (stall_cnt > 0) begin
                checks++;
                if (bus.pix_ready !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_addr !== AW'(5) || bus.mem_data !== hold_d) begin
                    errors++;
                    $display("FAIL stall_window: ready=%b we=%b addr=%0d data=%h, required 0/1/5/%h",
                             bus.pix_ready, bus.mem_we, bus.mem_addr, bus.mem_data, hold_d);
                end
                stall_cnt--;
            end
            @(negedge clk);
            if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) sent++;
            if (halt === 1'b1) break;
            if (reset_at >= 0 && wr_idx >= reset_at) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_data !== '0 || busy !== 1'b0 ||
                    halt !== 1'b0 || pix_count !== '0 || bus.pix_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset: we=%b addr=%0d data=%h busy=%b halt=%b cnt=%0d ready=%b, required all 0",
                             bus.mem_we, bus.mem_addr, bus.mem_data, busy, halt, pix_count, bus.pix_ready);
                end
                bus.pix_valid = 1'b0;
                bus.mem_stall = 1'b0;
                start = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
        bus.mem_stall = 1'b0;
        start = 1'b0;
        checks++;
        if (halt !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: halt=%b busy=%b, required 1/0", halt, busy);
        end
        checks++;
        if (pix_count !== AW'(FRAME) || wr_idx != FRAME) begin
            errors++;
            $display("FAIL write_count: pix_count=%0d writes=%0d, required %0d", pix_count, wr_idx, FRAME);
        end
        checks++;
        if (sent != NIN || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_count: accepted=%0d unwritten=%0d, required %0d/0", sent, exp_q.size(), NIN);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_data !== '0 || busy !== 1'b0 ||
            halt !== 1'b0 || pix_count !== '0) begin
            errors++;
            $display("FAIL reset_values: we=%b addr=%0d data=%h busy=%b halt=%b cnt=%0d, required all 0",
                     bus.mem_we, bus.mem_addr, bus.mem_data, busy, halt, pix_count);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_in = 8'h3C;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.pix_ready !== 1'b0 || bus.mem_we !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignore: ready=%b we=%b busy=%b, required 0/0/0", bus.pix_ready, bus.mem_we, busy);
            end
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic test_basic();
        run_frame(0, 0, 1'b0, -1, 1);
    endtask

    task automatic test_stall();
        run_frame(0, 1, 1'b0, -1, 1);
    endtask

    task automatic test_bubbles();
        run_frame(1, 0, 1'b0, -1, 1);
    endtask

    task automatic test_reset_mid();
        run_frame(0, 0, 1'b0, 8, 1);
        run_frame(0, 0, 1'b0, -1, 1);
    endtask

    task automatic test_restart();
        run_frame(2, 0, 1'b1, -1, 0);
        for (int r = 0; r < 3; r++) run_frame(2, 2, 1'b1, -1, 0);
    endtask

`ifdef BORDER_FILL_EN
    task automatic test_border();
        run_frame(0, 0, 1'b0, -1, 2);
    endtask
`endif

    initial begin
        bus.pix_in    = 8'h00;
        bus.pix_valid = 1'b0;
        bus.mem_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_bubbles();
        test_reset_mid();
        test_restart();
`ifdef BORDER_FILL_EN
        test_border();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
